key_entry_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 23 ++
 rtl/entry_timeout_cnt.sv | 42 ++++
 rtl/key_entry_ctrl.sv | 138 +++++++++++++
 tb/tb_key_entry_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the keypad-to-timer entry path.
//   Key codes delivered by the keypad front end, digit capacity of the
//   MM:SS entry buffer, entry FSM state type and default inactivity timeout.
package timer_pkg;

  localparam logic [4:0] KEY_MAX_DIGIT = 5'd9;
  localparam logic [4:0] KEY_ENTER     = 5'd10;
  localparam logic [4:0] KEY_CLEAR     = 5'd11;
  localparam logic [4:0] KEY_BKSP      = 5'd12;

  localparam int unsigned MAX_DIGITS     = 4;
  localparam int unsigned DEF_TIMEOUT_MS = 5000;

  typedef enum logic {
    ST_IDLE,
    ST_ENTRY
  } entry_state_e;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/entry_timeout_cnt.sv
// entry_timeout_cnt: inactivity tick counter for key entry.
//   Counts i_tick pulses while i_en is high; held at zero while i_en is low
//   or i_clr is high (clear has priority over a coincident tick).
//   o_expire pulses on the tick that would take the count past TIMEOUT-1.
// Ports:
//   i_clk    in   clock
//   i_rstn   in   asynchronous active-low reset
//   i_en     in   counting enabled (entry in progress)
//   i_clr    in   restart the count (key consumed)
//   i_tick   in   one-cycle time base tick
//   o_expire out  one-cycle strobe, combinational from current count
module entry_timeout_cnt #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          at_last;

  assign at_last  = (cnt_q == LAST);
  assign o_expire = i_en && !i_clr && i_tick && at_last;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (!i_en || i_clr) begin
      cnt_q <= '0;
    end else if (i_tick) begin
      cnt_q <= at_last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: collects up to four BCD digits (MM:SS) from the keypad,
//   supports CLEAR and BACKSPACE, range-checks seconds-tens on ENTER and
//   issues a one-cycle load strobe with the new preset to the timer core.
// Optional feature: define KEY_ENTRY_TIMEOUT_EN to abandon an entry after
//   TIMEOUT_MS i_pls_1k ticks without a key (acts like CLEAR, no error).
// Ports:
//   i_clk          in   system clock
//   i_rstn         in   asynchronous active-low reset
//   i_pls_1k       in   one-cycle 1 kHz tick
//   i_key_valid    in   key strobe, i_bcd_data valid same cycle
//   i_bcd_data     in   key code 0-9 digit, 10 ENTER, 11 CLEAR, 12 BKSP
//   o_set_time     out  last loaded preset {M1,M0,S1,S0}
//   o_load         out  one-cycle load strobe
//   o_err          out  one-cycle strobe on rejected ENTER
//   o_entry_active out  entry in progress
//   o_disp_data    out  digits being typed, right-aligned
//   o_digit_cnt    out  number of digits held (0-4)
module key_entry_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TIMEOUT_MS = DEF_TIMEOUT_MS
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_pls_1k,
  input  logic        i_key_valid,
  input  logic [4:0]  i_bcd_data,
  output logic [15:0] o_set_time,
  output logic        o_load,
  output logic        o_err,
  output logic        o_entry_active,
  output logic [15:0] o_disp_data,
  output logic [2:0]  o_digit_cnt
);

  localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);

  if (TIMEOUT_MS < 1) begin : g_bad_timeout
    $error("TIMEOUT_MS must be at least 1");
  end

  entry_state_e state_q;
  logic [15:0]  buf_q;
  logic [2:0]   cnt_q;
  logic [15:0]  set_time_q;
  logic         load_q;
  logic         err_q;
  logic         expire;

`ifdef KEY_ENTRY_TIMEOUT_EN
  entry_timeout_cnt #(
    .TIMEOUT (TIMEOUT_MS)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_en     (state_q == ST_ENTRY),
    .i_clr    (i_key_valid),
    .i_tick   (i_pls_1k),
    .o_expire (expire)
  );
`else
  logic unused_pls_1k;
  assign unused_pls_1k = i_pls_1k;
  assign expire        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      set_time_q <= '0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_q <= 1'b0;
      err_q  <= 1'b0;
      if (i_key_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            if (is_digit(i_bcd_data)) begin
              buf_q   <= {12'h000, i_bcd_data[3:0]};
              cnt_q   <= 3'd1;
              state_q <= ST_ENTRY;
            end
          end
          ST_ENTRY: begin
            if (is_digit(i_bcd_data)) begin
              // a fifth digit is silently dropped, buffer left intact
              if (cnt_q < CNT_MAX) begin
                buf_q <= {buf_q[11:0], i_bcd_data[3:0]};
                cnt_q <= cnt_q + 3'd1;
              end
            end else begin
              case (i_bcd_data)
                KEY_BKSP: begin
                  buf_q <= {4'h0, buf_q[15:4]};
                  cnt_q <= cnt_q - 3'd1;
                  if (cnt_q == 3'd1) state_q <= ST_IDLE;
                end
                KEY_CLEAR: begin
                  buf_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
                end
                KEY_ENTER: begin
                  // only seconds-tens needs a range check; minutes 00-99 all legal
                  if (buf_q[7:4] <= 4'd5) begin
                    set_time_q <= buf_q;
                    load_q     <= 1'b1;
                    buf_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= ST_IDLE;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end else if (expire) begin
        buf_q   <= '0;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign o_set_time     = set_time_q;
  assign o_load         = load_q;
  assign o_err          = err_q;
  assign o_entry_active = (state_q == ST_ENTRY);
  assign o_disp_data    = buf_q;
  assign o_digit_cnt    = cnt_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int TMO = 5;
`else
  localparam int TMO = 5000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pls = 1'b0;
  logic        kv = 1'b0;
  logic [4:0]  code = '0;
  logic [15:0] set_time, disp;
  logic        load, err, active;
  logic [2:0]  dcnt;

  key_entry_ctrl #(.TIMEOUT_MS(TMO)) dut (
    .i_clk          (clk),
    .i_rstn         (rst_n),
    .i_pls_1k       (pls),
    .i_key_valid    (kv),
    .i_bcd_data     (code),
    .o_set_time     (set_time),
    .o_load         (load),
    .o_err          (err),
    .o_entry_active (active),
    .o_disp_data    (disp),
    .o_digit_cnt    (dcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        load;
    logic        err;
    logic        active;
    logic [2:0]  cnt;
    logic [15:0] disp;
    logic [15:0] set_time;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: entry is simply a list of typed digits
  int          digs[$];
  logic [15:0] m_set;
  int          m_tc;

  function automatic void check(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [15:0] packed_digits();
    logic [15:0] v = '0;
    foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
    return v;
  endfunction

  function automatic void model_reset();
    digs.delete();
    m_set = '0;
    m_tc  = 0;
  endfunction

  function automatic exp_t model_step(logic v, int c, logic t);
    exp_t e;
    int   s1;
    e = '0;
    if (v) begin
      m_tc = 0;
      if (c <= 9) begin
        if (digs.size() == 0) digs.push_back(c);
        else if (digs.size() < 4) digs.push_back(c);
      end else if (digs.size() > 0) begin
        if (c == 10) begin
          s1 = (digs.size() >= 2) ? digs[digs.size()-2] : 0;
          if (s1 <= 5) begin
            m_set = packed_digits();
            e.load = 1'b1;
            digs.delete();
          end else begin
            e.err = 1'b1;
          end
        end else if (c == 11) begin
          digs.delete();
        end else if (c == 12) begin
          void'(digs.pop_back());
        end
      end
    end else begin
`ifdef KEY_ENTRY_TIMEOUT_EN
      if (digs.size() > 0 && t) begin
        if (m_tc == TMO - 1) begin
          digs.delete();
          m_tc = 0;
        end else begin
          m_tc++;
        end
      end
`endif
    end
    if (digs.size() == 0) m_tc = 0;
    e.active   = digs.size() > 0;
    e.cnt      = 3'(digs.size());
    e.disp     = packed_digits();
    e.set_time = m_set;
    return e;
  endfunction

  // drive one cycle, push expectation once the edge has been taken
  task automatic step(input logic v, input int c, input logic t);
    exp_t e;
    kv   = v;
    code = 5'(c);
    pls  = t;
    @(posedge clk);
    e = model_step(v, c, t);
    sb.push_back(e);
    #1;
    kv  = 1'b0;
    pls = 1'b0;
  endtask

  task automatic key(input int c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 0, 1'b1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_set_time"}, set_time, 16'h0000);
    check({tag, "_load"}, 16'(load), 16'h0);
    check({tag, "_err"}, 16'(err), 16'h0);
    check({tag, "_active"}, 16'(active), 16'h0);
    check({tag, "_disp"}, disp, 16'h0000);
    check({tag, "_cnt"}, 16'(dcnt), 16'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("load", 16'(load), 16'(e.load));
      check("err", 16'(err), 16'(e.err));
      check("active", 16'(active), 16'(e.active));
      check("digit_cnt", 16'(dcnt), 16'(e.cnt));
      check("disp_data", disp, e.disp);
      check("set_time", set_time, e.set_time);
    end
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // full entry and load
    key(1); key(2); key(3); key(4); key(10); idle(2);
    // rejected ENTER then corrected
    key(9); key(0); key(10); idle(1);
    key(12); key(12); key(4); key(5); key(10); idle(2);
    // fifth digit ignored, backspace to empty
    key(1); key(2); key(3); key(4); key(5); idle(1);
    key(12); key(12); key(12); key(12); idle(1);
    // clear, then ENTER in IDLE does nothing
    key(7); key(11); key(10); idle(1);
    // ignored codes and single-digit / zero presets
    key(20); key(0); key(31); key(10); idle(1);
    key(6); key(10); idle(1);
    // control keys in IDLE
    key(12); key(11); key(10); idle(1);

`ifdef KEY_ENTRY_TIMEOUT_EN
    key(3); tick(); tick(); tick(); tick(); tick(); idle(1);
    key(3); tick(); tick(); key(20); tick(); tick(); tick(); idle(1);
    key(8); tick(); tick(); tick(); tick(); step(1'b1, 4, 1'b1); tick(); idle(1);
`else
    key(3); repeat (10) tick(); idle(1);
`endif

    // asynchronous reset in the middle of an entry
    key(1); key(2); idle(1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    key(6); idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, t;
      int   c;
      v = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      if (r < 55)      c = $urandom_range(0, 9);
      else if (r < 67) c = 10;
      else if (r < 74) c = 11;
      else if (r < 85) c = 12;
      else             c = $urandom_range(13, 31);
      step(v, c, t);
    end

    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
